// File: rtl/i2s_dma_pkg.sv
// Shared types and defaults for the I2S refill DMA scheduler.
// State encodings are fixed so waveforms decode consistently across tools.
package i2s_dma_pkg;

    localparam int MAX_BURST_DEF = 16;
    localparam int CNT_W         = 24;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_DATA   = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/i2s_burst_sizer.sv
// Burst length = min(remaining, MAX_BURST, room left before the ring end).
// Keeps every burst inside the circular buffer.
module i2s_burst_sizer
    import i2s_dma_pkg::*;
#(
    parameter int MAX_BURST   = MAX_BURST_DEF,
    parameter int BURST_WIDTH = 5
) (
    input  logic [CNT_W-1:0]       i_remaining,
    input  logic [CNT_W-1:0]       i_len,
    input  logic [CNT_W-1:0]       i_pos,
    output logic [BURST_WIDTH-1:0] o_burst
);

    localparam logic [CNT_W-1:0] MAXB = CNT_W'(MAX_BURST);

    logic [CNT_W-1:0] w_room;
    logic [CNT_W-1:0] w_min_a;
    logic [CNT_W-1:0] w_min;

    assign w_room  = i_len - i_pos;
    assign w_min_a = (i_remaining < MAXB) ? i_remaining : MAXB;
    assign w_min   = (w_min_a < w_room) ? w_min_a : w_room;
    assign o_burst = BURST_WIDTH'(w_min);

endmodule

// File: rtl/i2s_dma_scheduler.sv
// Turns one refill request into bounded read bursts over a circular buffer
// and streams the returned dwords to the I2S memory controller.
module i2s_dma_scheduler
    import i2s_dma_pkg::*;
#(
    parameter int MAX_BURST   = MAX_BURST_DEF,
    parameter int BURST_WIDTH = 5,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [ADDR_WIDTH-1:0]  buf_base,
    input  logic [23:0]            buf_words,
    input  logic                   request_data,
    input  logic [23:0]            request_size,
    output logic                   request_finished,
    output logic                   memory_data_strobe,
    output logic [31:0]            memory_data,
    output logic                   mem_rd_req,
    input  logic                   mem_rd_ack,
    output logic [ADDR_WIDTH-1:0]  mem_rd_addr,
    output logic [BURST_WIDTH-1:0] mem_rd_len,
    input  logic                   mem_rd_valid,
    input  logic [31:0]            mem_rd_data,
    output logic                   busy,
    output logic [23:0]            read_pos,
    output logic [15:0]            wrap_count
);

    state_t                 r_state;
    logic [CNT_W-1:0]       r_remaining;
    logic [ADDR_WIDTH-1:0]  r_base;
    logic [CNT_W-1:0]       r_len;
    logic [BURST_WIDTH-1:0] r_beats;
    logic [CNT_W-1:0]       r_pos;
    logic [15:0]            r_wrap;
    logic                   r_req;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [BURST_WIDTH-1:0] r_rdlen;
    logic                   r_strobe;
    logic [31:0]            r_data;
    logic                   r_finished;

    logic [BURST_WIDTH-1:0] w_burst;
    logic [CNT_W-1:0]       w_pos_next;
    logic                   w_wrap;

    i2s_burst_sizer #(
        .MAX_BURST   (MAX_BURST),
        .BURST_WIDTH (BURST_WIDTH)
    ) u_sizer (
        .i_remaining (r_remaining),
        .i_len       (r_len),
        .i_pos       (r_pos),
        .o_burst     (w_burst)
    );

    assign w_pos_next = r_pos + 24'd1;
    assign w_wrap     = (w_pos_next == r_len);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_base      <= '0;
            r_len       <= '0;
            r_beats     <= '0;
            r_pos       <= '0;
            r_wrap      <= '0;
            r_req       <= 1'b0;
            r_addr      <= '0;
            r_rdlen     <= '0;
            r_strobe    <= 1'b0;
            r_data      <= '0;
            r_finished  <= 1'b0;
        end else begin
            r_strobe   <= 1'b0;
            r_finished <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (request_data && enable && buf_words != '0) begin
                        r_remaining <= request_size;
                        r_base      <= buf_base;
                        r_len       <= buf_words;
                        // Ring shrank since last request: restart at base
                        if (r_pos >= buf_words)
                            r_pos <= '0;
                        r_state <= (request_size == '0) ? ST_FINISH : ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (!r_req) begin
                        r_req   <= 1'b1;
                        r_addr  <= r_base + ADDR_WIDTH'(r_pos);
                        r_rdlen <= w_burst;
                    end else if (mem_rd_ack) begin
                        r_req   <= 1'b0;
                        r_beats <= r_rdlen;
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (mem_rd_valid) begin
                        r_strobe    <= 1'b1;
                        r_data      <= mem_rd_data;
                        r_beats     <= r_beats - BURST_WIDTH'(1);
                        r_remaining <= r_remaining - 24'd1;
                        if (w_wrap) begin
                            r_pos  <= '0;
                            r_wrap <= r_wrap + 16'd1;
                        end else begin
                            r_pos <= w_pos_next;
                        end
                        if (r_beats == BURST_WIDTH'(1)) begin
                            if (r_remaining == 24'd1 || !enable)
                                r_state <= ST_FINISH;
                            else
                                r_state <= ST_ISSUE;
                        end
                    end
                end
                ST_FINISH: begin
                    r_finished <= 1'b1;
                    r_state    <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign request_finished   = r_finished;
    assign memory_data_strobe = r_strobe;
    assign memory_data        = r_data;
    assign mem_rd_req         = r_req;
    assign mem_rd_addr        = r_addr;
    assign mem_rd_len         = r_rdlen;
    assign busy               = (r_state != ST_IDLE);
    assign read_pos           = r_pos;
    assign wrap_count         = r_wrap;

endmodule
